exec_stage: RTL and testbench

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/simplerisc_pkg.sv | 57 +++++
 rtl/exec_stage_alu.sv | 33 +++
 rtl/iter_divider.sv | 74 +++++++
 rtl/exec_stage.sv | 151 +++++++++++++++
 tb/tb_exec_stage.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simplerisc_pkg.sv
// rtl/simplerisc_pkg.sv - shared opcodes, datapath width, FSM encoding and divide helper
// Purpose : common definitions for the execute stage and its sub-modules.
// Contents: XLEN, ALU opcode constants, exec FSM state type, signed div/mod helper
//           used by the single-cycle divide path.
package simplerisc_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8;
   localparam logic [3:0] OP_PASS = 4'd9;
   localparam logic [3:0] OP_NOT  = 4'd10;
   localparam logic [3:0] OP_MUL  = 4'd11;
   localparam logic [3:0] OP_DIV  = 4'd12;
   localparam logic [3:0] OP_MOD  = 4'd13;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0] quo;
      logic [XLEN-1:0] rem;
   } divmod_t;

   // Signed divide on magnitudes so that 0x80000000 / -1 wraps to 0x80000000
   // instead of overflowing; divide by zero gives all-ones / dividend.
   function automatic divmod_t signed_divmod(input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
      divmod_t         r;
      logic [XLEN-1:0] ma, mb, uq, ur;
      ma = a[XLEN-1] ? -a : a;
      mb = b[XLEN-1] ? -b : b;
      uq = '0;
      ur = '0;
      if (b == '0) begin
         r.quo = '1;
         r.rem = a;
      end else begin
         uq    = ma / mb;
         ur    = ma % mb;
         r.quo = (a[XLEN-1] ^ b[XLEN-1]) ? -uq : uq;
         r.rem = a[XLEN-1] ? -ur : ur;
      end
      return r;
   endfunction

endpackage

// File: rtl/exec_stage_alu.sv
// rtl/exec_stage_alu.sv - combinational ALU for all single-cycle opcodes
// Purpose : computes ADD/SUB/logic/SLT/shifts/PASS/NOT/MUL results.
// Ports   : op_i opcode, a_i/b_i operands, y_o result (0 for DIV/MOD and
//           unknown opcodes; the divide paths live in the stage).
module exec_stage_alu
   import simplerisc_pkg::*;
(
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] y_o
);

   always_comb begin
      y_o = '0;
      case (op_i)
         OP_ADD:  y_o = a_i + b_i;
         OP_SUB:  y_o = a_i - b_i;
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = a_i ^ b_i;
         OP_SLT:  y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         OP_SLL:  y_o = a_i << b_i[4:0];
         OP_SRL:  y_o = a_i >> b_i[4:0];
         OP_SRA:  y_o = $signed(a_i) >>> b_i[4:0];
         OP_PASS: y_o = b_i;
         OP_NOT:  y_o = ~b_i;
         OP_MUL:  y_o = a_i * b_i;
         default: y_o = '0;
      endcase
   end

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - 32-iteration restoring signed divider with abort
// Purpose : one quotient bit per cycle on operand magnitudes; signs applied
//           to the final step so results appear on the last iteration edge.
// Ports   : clk, rst (async, high); start_i loads a_i/b_i (b_i != 0);
//           abort_i cancels a running divide; done_o is high in the cycle
//           whose rising edge completes the last iteration, with quo_o/rem_o
//           carrying the signed results in that same cycle.
module iter_divider
   import simplerisc_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            done_o,
   output logic [XLEN-1:0] quo_o,
   output logic [XLEN-1:0] rem_o
);

   logic            run_q;
   logic [4:0]      cnt_q;
   logic [XLEN-1:0] rem_q, quo_q, dvs_q;
   logic            neg_quo_q, neg_rem_q;

   logic [XLEN:0]   shift, diff;
   logic [XLEN-1:0] rem_d, quo_d;
   logic            qbit;

   // quo_q starts as the dividend magnitude; its MSB is shifted into the
   // partial remainder while quotient bits enter at the LSB.
   always_comb begin
      shift = {rem_q, quo_q[XLEN-1]};
      diff  = shift - {1'b0, dvs_q};
      qbit  = ~diff[XLEN];
      rem_d = qbit ? diff[XLEN-1:0] : shift[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], qbit};
   end

   assign done_o = run_q && (cnt_q == 5'd31);
   assign quo_o  = neg_quo_q ? -quo_d : quo_d;
   assign rem_o  = neg_rem_q ? -rem_d : rem_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q     <= 1'b0;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else if (abort_i) begin
         run_q <= 1'b0;
      end else if (start_i) begin
         run_q     <= 1'b1;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= a_i[XLEN-1] ? -a_i : a_i;
         dvs_q     <= b_i[XLEN-1] ? -b_i : b_i;
         neg_quo_q <= a_i[XLEN-1] ^ b_i[XLEN-1];
         neg_rem_q <= a_i[XLEN-1];
      end else if (run_q) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_q + 5'd1;
         if (cnt_q == 5'd31) begin
            run_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute stage: ALU plus signed divide with valid/ready handshakes
// Purpose : accepts one op from decode, produces one registered result for
//           writeback. Macro EXEC_ITER_DIV_EN selects the 32-cycle iterative
//           divider; without it DIV/MOD finish in one cycle combinationally.
// Ports   : clk, rst (async, high), flush (sync kill);
//           in_valid/in_ready, in_op, in_a, in_b, in_rd  - issue side;
//           out_valid/out_ready, out_y, out_zero, out_rd - result side;
//           busy - high while a divide is iterating.
module exec_stage #(
   parameter int RD_W = 5,
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic [RD_W-1:0] in_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_y,
   output logic            out_zero,
   output logic [RD_W-1:0] out_rd,
   output logic            busy
);

   import simplerisc_pkg::*;

   state_e          state_q;
   logic            out_valid_q, out_zero_q, mod_pend_q;
   logic [XLEN-1:0] out_y_q;
   logic [RD_W-1:0] out_rd_q, rd_pend_q;

   logic            accept, is_mod, is_divop, iter_start, div_done;
   logic [XLEN-1:0] alu_y, single_y, div_quo, div_rem, div_y;

   assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !flush;
   assign accept   = in_valid && in_ready;
   assign is_mod   = (in_op == OP_MOD);
   assign is_divop = (in_op == OP_DIV) || is_mod;

   exec_stage_alu u_alu (
      .op_i (in_op),
      .a_i  (in_a),
      .b_i  (in_b),
      .y_o  (alu_y)
   );

`ifdef EXEC_ITER_DIV_EN
   logic b_zero;
   assign b_zero     = (in_b == '0);
   assign iter_start = accept && is_divop && !b_zero;
   assign busy       = (state_q == ST_DIV);

   iter_divider u_div (
      .clk     (clk),
      .rst     (rst),
      .start_i (iter_start),
      .abort_i (flush),
      .a_i     (in_a),
      .b_i     (in_b),
      .done_o  (div_done),
      .quo_o   (div_quo),
      .rem_o   (div_rem)
   );

   // Only divide-by-zero reaches the single-cycle path here.
   always_comb begin
      single_y = alu_y;
      if (is_divop) begin
         single_y = is_mod ? in_a : '1;
      end
   end
`else
   divmod_t dm;
   assign dm         = signed_divmod(in_a, in_b);
   assign iter_start = 1'b0;
   assign div_done   = 1'b0;
   assign div_quo    = '0;
   assign div_rem    = '0;
   assign busy       = 1'b0;

   always_comb begin
      single_y = alu_y;
      if (is_divop) begin
         single_y = is_mod ? dm.rem : dm.quo;
      end
   end
`endif

   assign div_y = mod_pend_q ? div_rem : div_quo;

   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_zero  = out_zero_q;
   assign out_rd    = out_rd_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_zero_q  <= 1'b0;
         out_rd_q    <= '0;
         rd_pend_q   <= '0;
         mod_pend_q  <= 1'b0;
      end else if (flush) begin
         // Flush beats both accept and output transfer.
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (out_valid_q && out_ready) begin
                  out_valid_q <= 1'b0;
               end
               if (iter_start) begin
                  state_q    <= ST_DIV;
                  rd_pend_q  <= in_rd;
                  mod_pend_q <= is_mod;
               end else if (accept) begin
                  out_valid_q <= 1'b1;
                  out_y_q     <= single_y;
                  out_zero_q  <= (single_y == '0);
                  out_rd_q    <= in_rd;
               end
            end
            ST_DIV: begin
               if (div_done) begin
                  state_q     <= ST_HOLD;
                  out_valid_q <= 1'b1;
                  out_y_q     <= div_y;
                  out_zero_q  <= (div_y == '0);
                  out_rd_q    <= rd_pend_q;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - self-checking bench for exec_stage (honours EXEC_ITER_DIV_EN)
module tb_exec_stage;

   localparam int RD_W = 5;
`ifdef EXEC_ITER_DIV_EN
   localparam bit ITER = 1'b1;
`else
   localparam bit ITER = 1'b0;
`endif
   localparam int DIV_LAT = ITER ? 33 : 1;

   localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  AND = 4'd2,  OR  = 4'd3;
   localparam logic [3:0] XOR = 4'd4,  SLT = 4'd5,  SLL = 4'd6,  SRL = 4'd7;
   localparam logic [3:0] SRA = 4'd8,  PASS = 4'd9, NOT = 4'd10, MUL = 4'd11;
   localparam logic [3:0] DIV = 4'd12, MOD = 4'd13;

   logic            clk = 1'b0;
   logic            rst, flush, in_valid, in_ready, out_valid, out_ready, out_zero, busy;
   logic [3:0]      in_op;
   logic [31:0]     in_a, in_b, out_y;
   logic [RD_W-1:0] in_rd, out_rd;

   always #5 clk = ~clk;

   exec_stage #(.RD_W(RD_W), .XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_rd     (in_rd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_zero  (out_zero),
      .out_rd    (out_rd),
      .busy      (busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference results from plain 64-bit signed arithmetic.
   function automatic logic [31:0] ref_y(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         ADD:  return a + b;
         SUB:  return a - b;
         AND:  return a & b;
         OR:   return a | b;
         XOR:  return a ^ b;
         SLT:  return (sa < sb) ? 32'd1 : 32'd0;
         SLL:  return a << b[4:0];
         SRL:  return a >> b[4:0];
         SRA:  return 32'(sa >>> b[4:0]);
         PASS: return b;
         NOT:  return ~b;
         MUL:  return 32'(sa * sb);
         DIV:  return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
         MOD:  return (b == 0) ? a : 32'(sa % sb);
         default: return 32'd0;
      endcase
   endfunction

   // Scoreboard: pending results with the cycle from which they must be visible.
   typedef struct {
      logic [31:0]     y;
      logic [RD_W-1:0] rd;
      int              due;
      bit              iter;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;

   function automatic bit exp_valid();
      return (sb.size() > 0) && (cyc >= sb[0].due);
   endfunction

   function automatic bit exp_ready();
      return !flush && ((sb.size() == 0) || (exp_valid() && out_ready && !sb[0].iter));
   endfunction

   function automatic bit exp_busy();
      return (sb.size() > 0) && sb[0].iter && (cyc < sb[0].due);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sb.delete();
      end else begin
         bit   xfer, acc;
         exp_t e;
         xfer = exp_valid() && out_ready;
         acc  = in_valid && exp_ready();
         cyc++;
         if (flush) begin
            sb.delete();
         end else begin
            if (xfer) void'(sb.pop_front());
            if (acc) begin
               e.iter = ITER && ((in_op == DIV) || (in_op == MOD)) && (in_b != 0);
               e.y    = ref_y(in_op, in_a, in_b);
               e.rd   = in_rd;
               e.due  = cyc + (e.iter ? 32 : 0);
               sb.push_back(e);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("m_rst_valid", {31'd0, out_valid}, 32'd0);
         chk("m_rst_busy", {31'd0, busy}, 32'd0);
      end else begin
         chk("m_valid", {31'd0, out_valid}, {31'd0, exp_valid()});
         chk("m_in_ready", {31'd0, in_ready}, {31'd0, exp_ready()});
         chk("m_busy", {31'd0, busy}, {31'd0, exp_busy()});
         if (exp_valid()) begin
            chk("m_y", out_y, sb[0].y);
            chk("m_zero", {31'd0, out_zero}, {31'd0, (sb[0].y == 0)});
            chk("m_rd", {27'd0, out_rd}, {27'd0, sb[0].rd});
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [RD_W-1:0] rd, output int waits);
      in_op = op; in_a = a; in_b = b; in_rd = rd; in_valid = 1'b1;
      waits = 0;
      while (waits < 200) begin
         @(negedge clk);
         if (in_ready) break;
         waits++;
      end
      chk("issue_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [RD_W-1:0] rd, input int lat,
                         input logic [31:0] exp);
      int w;
      issue(op, a, b, rd, w);
      for (int k = 1; k < lat; k++) begin
         @(negedge clk);
         chk({name, "_wait_valid"}, {31'd0, out_valid}, 32'd0);
         chk({name, "_wait_ready"}, {31'd0, in_ready}, 32'd0);
         chk({name, "_wait_busy"}, {31'd0, busy}, 32'd1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, "_y"}, out_y, exp);
      chk({name, "_zero"}, {31'd0, out_zero}, {31'd0, (exp == 0)});
      chk({name, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom % 6)
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return $urandom_range(0, 15);
         4:       return -($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got still running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
      in_rd = '0; out_ready = 1'b1;

      @(negedge clk);
      chk("reset_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_y", out_y, 32'd0);
      chk("reset_zero", {31'd0, out_zero}, 32'd0);
      chk("reset_rd", {27'd0, out_rd}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      chk("model_div", ref_y(DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      chk("model_mod", ref_y(MOD, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      chk("model_ovf", ref_y(DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      chk("model_sra", ref_y(SRA, 32'h8000_0000, 32'h24), 32'hF800_0000);

      run_op("add_ovf", ADD, 32'h7FFF_FFFF, 32'd1, 5'd3, 1, 32'h8000_0000);
      run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, DIV_LAT, 32'hFFFF_FFFD);
      run_op("mod_neg", MOD, 32'hFFFF_FFF9, 32'd2, 5'd6, DIV_LAT, 32'hFFFF_FFFF);
      run_op("div_zero", DIV, 32'd5, 32'd0, 5'd1, 1, 32'hFFFF_FFFF);
      run_op("mod_zero", MOD, 32'd5, 32'd0, 5'd2, 1, 32'd5);
      run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, DIV_LAT, 32'h8000_0000);
      run_op("mod_ovf", MOD, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, DIV_LAT, 32'd0);
      run_op("unknown", 4'hF, 32'd1, 32'd2, 5'd10, 1, 32'd0);
      run_op("sra", SRA, 32'h8000_0000, 32'h24, 5'd11, 1, 32'hF800_0000);
      run_op("slt", SLT, 32'hFFFF_FFFF, 32'd1, 5'd12, 1, 32'd1);

      // Result held while writeback stalls.
      out_ready = 1'b0;
      issue(SUB, 32'd4, 32'd4, 5'd7, w);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_y", out_y, 32'd0);
         chk("hold_zero", {31'd0, out_zero}, 32'd1);
         chk("hold_rd", {27'd0, out_rd}, 32'd7);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("hold_release_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_once", {31'd0, out_valid}, 32'd0);

      // Flush ten cycles into a divide.
      issue(DIV, 32'd100, 32'd3, 5'd9, w);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_busy", {31'd0, busy}, 32'd0);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         chk("flush_stays_idle", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk); #1;
      run_op("after_flush_add", ADD, 32'd1, 32'd2, 5'd4, 1, 32'd3);

      // Asynchronous reset mid-divide.
      issue(DIV, 32'd1000, 32'd7, 5'd2, w);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_y", out_y, 32'd0);
      chk("arst_zero", {31'd0, out_zero}, 32'd0);
      chk("arst_rd", {27'd0, out_rd}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      issue(ADD, 32'd10, 32'd20, 5'd4, w);
      chk("arst_first_accept_waits", w, 32'd0);
      @(negedge clk);
      chk("arst_add_valid", {31'd0, out_valid}, 32'd1);
      chk("arst_add_y", out_y, 32'd30);
      @(posedge clk); #1;

      // Random traffic against the scoreboard.
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom % 3) != 0;
         in_op     = 4'($urandom_range(0, 15));
         in_a      = pick_val();
         in_b      = pick_val();
         in_rd     = RD_W'($urandom);
         out_ready = ($urandom % 4) != 0;
         flush     = ($urandom % 60) == 0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      @(negedge clk);
      chk("drain_valid", {31'd0, out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
